pcs_40g_rx_block_sync: RTL

Per-lane 66b block synchronisation for the 40GBASE-R receive PCS: monitors the 2-bit sync header of each block delivered by the RX gearbox, runs the Clause 82 block-lock state machine, and commands a one-block-bit slip until header alignment is found. Sits between the RX gearbox and alignment-marker lock/deskew in `pcs_40g_rx`. It is the receive-side counterpart of the TX block encoder/gearbox path, and is instantiated once per lane (LANE_N = 4). Block data is passed through registered, qualified by lock.

---
 rtl/pcs_40g_rx_block_sync.sv | 92 +++++++++
 1 files changed

// File: rtl/pcs_40g_rx_block_sync.sv
// pcs_40g_rx_block_sync: per-lane 66b sync-header block lock with one-bit slip requests
module pcs_40g_rx_block_sync #(
    parameter int DATA_W       = 64,
    parameter int SH_CNT_MAX   = 1024,
    parameter int SH_INVLD_MAX = 65,
    parameter int SLIP_WAIT_N  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [1:0]        head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              slip_o,
    output logic              lock_o,
    output logic              valid_o,
    output logic [1:0]        head_o,
    output logic [DATA_W-1:0] data_o
);
    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVLD_MAX + 1);
    localparam int WW = SLIP_WAIT_N > 0 ? $clog2(SLIP_WAIT_N + 1) : 1;
    typedef enum logic [1:0] {TEST, SLIP, WAIT} state_t;
    state_t state_q, state_d;
    logic lock_q, lock_d;
    logic [CW-1:0] sh_cnt_q, sh_cnt_d, cnt_n;
    logic [IW-1:0] sh_invld_q, sh_invld_d, inv_n;
    logic [WW-1:0] wait_q, wait_d;
    logic valid_q;
    logic [1:0] head_q;
    logic [DATA_W-1:0] data_q;
    logic sh_ok, test_beat, slip_hit, win_end, wait_beat, wait_end;
    assign sh_ok     = head_i[1] ^ head_i[0];
    assign cnt_n     = sh_cnt_q + 1'b1;
    assign inv_n     = sh_invld_q + IW'(!sh_ok);
    assign test_beat = valid_i && state_q == TEST;
    assign slip_hit  = test_beat && !sh_ok && (!lock_q || inv_n == IW'(SH_INVLD_MAX));
    assign win_end   = test_beat && cnt_n == CW'(SH_CNT_MAX);
    assign wait_beat = valid_i && state_q == WAIT;
    assign wait_end  = wait_beat && wait_q == WW'(SLIP_WAIT_N - 1);
    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= TEST;
        else       state_q <= state_d;
    end
    // Next state: a slip lasts one cycle, then the gearbox gets SLIP_WAIT_N beats to settle
    always_comb begin
        state_d = slip_hit ? SLIP :
                  state_q == SLIP ? (SLIP_WAIT_N > 0 ? WAIT : TEST) :
                  wait_end ? TEST : state_q;
    end
    // Outputs decoded from state
    always_comb begin
        slip_o = state_q == SLIP;
        lock_o = lock_q;
    end
    // Lock and window counters; slip has priority over the window-end reset
    always_comb begin
        lock_d     = slip_hit ? 1'b0 : (win_end && inv_n == '0) ? 1'b1 : lock_q;
        sh_cnt_d   = (slip_hit || win_end) ? '0 : test_beat ? cnt_n : sh_cnt_q;
        sh_invld_d = (slip_hit || win_end) ? '0 : test_beat ? inv_n : sh_invld_q;
        wait_d     = wait_end ? '0 : wait_beat ? wait_q + 1'b1 : wait_q;
    end
    // Counter and lock registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            sh_cnt_q   <= '0;
            sh_invld_q <= '0;
            wait_q     <= '0;
        end else begin
            lock_q     <= lock_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_invld_q <= sh_invld_d;
            wait_q     <= wait_d;
        end
    end
    // Registered pass-through, forwarded only with the pre-update lock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            head_q  <= 2'b00;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i && lock_q && state_q == TEST;
            head_q  <= valid_i ? head_i : head_q;
            data_q  <= valid_i ? data_i : data_q;
        end
    end
    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign data_o  = data_q;
endmodule
